// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, one-outstanding imem fetch FSM,
// and the IF/ID pipeline register feeding decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        stall_if,
    input  logic        flush_if_id,
    output logic [31:0] pc_o,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_PC_Plus_4,
    output logic [31:0] if_id_Inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pp4_q, pp4_d;

    logic        accept;
    logic [31:0] acc_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            hold_buf_q <= '0;
            valid_q    <= 1'b0;
            inst_q     <= NOP_INST;
            pp4_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            hold_buf_q <= hold_buf_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pp4_q      <= pp4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        hold_buf_d = hold_buf_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        pp4_d      = pp4_q;
        accept     = 1'b0;
        acc_word   = imem_rdata;

        unique case (state_q)
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!stall_if) begin
                        accept  = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_if) begin
                    accept   = 1'b1;
                    acc_word = hold_buf_q;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (flush_if_id) begin
            pc_d       = pc_next;
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            hold_buf_d = '0;
            unique case (state_q)
                S_WAIT: begin
                    // Outstanding response belongs to the old path.
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else if (accept) begin
            valid_d = 1'b1;
            inst_d  = acc_word;
            pp4_d   = pc_q + 32'd4;
            pc_d    = pc_next;
        end else if (!stall_if) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    assign pc_o            = pc_q;
    assign imem_req        = reset && (state_q == S_REQ);
    assign imem_addr       = pc_q;
    assign if_id_valid     = valid_q;
    assign if_id_PC_Plus_4 = pp4_q;
    assign if_id_Inst      = inst_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with immediate-assertion checks.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        stall_if;
    logic        flush_if_id;
    logic [31:0] pc_o;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_PC_Plus_4;
    logic [31:0] if_id_Inst;

    int n_chk  = 0;
    int n_fail = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc_next         (pc_next),
        .stall_if        (stall_if),
        .flush_if_id     (flush_if_id),
        .pc_o            (pc_o),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_id_valid     (if_id_valid),
        .if_id_PC_Plus_4 (if_id_PC_Plus_4),
        .if_id_Inst      (if_id_Inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v,
                            input logic [31:0] inst, input logic [31:0] pp4);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, "_inst"}, if_id_Inst, inst);
        chk({tag, "_pp4"}, if_id_PC_Plus_4, pp4);
    endtask

    initial begin
        reset       = 1'b0;
        pc_next     = 32'h0;
        stall_if    = 1'b0;
        flush_if_id = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        edge_step();
        edge_step();

        // reset state
        chk("rst_pc", pc_o, 32'h0040_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);

        // test 1: basic fetch
        reset = 1'b1;
        #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0040_0000);
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0004;
        edge_step();
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0001;
        edge_step();
        chk_ifid("t1", 1'b1, 32'h2008_0001, 32'h0040_0004);
        chk("t1_pc", pc_o, 32'h0040_0004);
        imem_rvalid = 1'b0;
        chk("t1_req2", {31'd0, imem_req}, 32'd1);
        chk("t1_addr2", imem_addr, 32'h0040_0004);

        // test 2: stall holds response in S_HOLD
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0008;
        edge_step();
        chk_ifid("t2_bub", 1'b0, 32'h0, 32'h0040_0004);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C09_0000;
        stall_if    = 1'b1;
        edge_step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            chk_ifid("t2_frz", 1'b0, 32'h0, 32'h0040_0004);
            chk("t2_frz_pc", pc_o, 32'h0040_0004);
            chk("t2_frz_req", {31'd0, imem_req}, 32'd0);
            edge_step();
        end
        chk_ifid("t2_frz3", 1'b0, 32'h0, 32'h0040_0004);
        stall_if = 1'b0;
        edge_step();
        chk_ifid("t2", 1'b1, 32'h8C09_0000, 32'h0040_0008);
        chk("t2_pc", pc_o, 32'h0040_0008);
        chk("t2_addr", imem_addr, 32'h0040_0008);

        // test 3: flush while waiting, late response dropped
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_000C;
        edge_step();
        chk_ifid("t3_bub", 1'b0, 32'h0, 32'h0040_0008);
        imem_gnt    = 1'b0;
        flush_if_id = 1'b1;
        pc_next     = 32'h0040_0100;
        edge_step();
        chk("t3_pc", pc_o, 32'h0040_0100);
        chk("t3_req", {31'd0, imem_req}, 32'd0);
        flush_if_id = 1'b0;
        edge_step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("t3", 1'b0, 32'h0, 32'h0040_0008);
        chk("t3_req2", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h0040_0100);

        // test 4: flush coincident with grant
        imem_gnt    = 1'b1;
        flush_if_id = 1'b1;
        pc_next     = 32'h0040_0200;
        edge_step();
        chk("t4_pc", pc_o, 32'h0040_0200);
        chk("t4_req", {31'd0, imem_req}, 32'd0);
        imem_gnt    = 1'b0;
        flush_if_id = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("t4_drop", 1'b0, 32'h0, 32'h0040_0008);
        chk("t4_req2", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h0040_0200);
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0204;
        edge_step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("t4", 1'b1, 32'h2222_2222, 32'h0040_0204);

        // test 5: reset during S_WAIT, stale rvalid ignored
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0208;
        edge_step();
        imem_gnt = 1'b0;
        reset    = 1'b0;
        #1;
        chk("t5_rst_pc", pc_o, 32'h0040_0000);
        chk("t5_rst_req", {31'd0, imem_req}, 32'd0);
        chk_ifid("t5_rst", 1'b0, 32'h0, 32'h0);
        edge_step();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("t5", 1'b0, 32'h0, 32'h0);
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr, 32'h0040_0000);

        // test 6: flush beats stall in S_HOLD
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0004;
        edge_step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        stall_if    = 1'b1;
        edge_step();
        imem_rvalid = 1'b0;
        chk("t6_hold_req", {31'd0, imem_req}, 32'd0);
        flush_if_id = 1'b1;
        pc_next     = 32'h0040_0300;
        edge_step();
        flush_if_id = 1'b0;
        stall_if    = 1'b0;
        chk("t6_pc", pc_o, 32'h0040_0300);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'h0040_0300);
        chk_ifid("t6", 1'b0, 32'h0, 32'h0);
        imem_gnt = 1'b1;
        pc_next  = 32'h0040_0304;
        edge_step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("t6_new", 1'b1, 32'h5555_5555, 32'h0040_0304);

        // PC+4 wraps modulo 2^32
        flush_if_id = 1'b1;
        pc_next     = 32'hFFFF_FFFC;
        edge_step();
        flush_if_id = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        pc_next  = 32'h0000_0000;
        edge_step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h6666_6666;
        edge_step();
        imem_rvalid = 1'b0;
        chk_ifid("wrap", 1'b1, 32'h6666_6666, 32'h0000_0000);
        chk("wrap_pc", pc_o, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined CPU. It holds the architectural PC register and fetches through a one-outstanding req/gnt/rvalid instruction-memory port. It drives the IF/ID pipeline register consumed by the decode stage. Each cycle it samples the next-PC value from the next-PC select logic, and it feeds the current PC (pc_o) back to that logic.

Parameters:
RESET_PC, 32'h0040_0000, PC value after reset.
NOP_INST, 32'h0000_0000, instruction written into IF/ID for bubbles and flushes.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low (asserted when 0).
pc_next  in  32  next PC from the next-PC select logic; carries the redirect target in a flush cycle.
stall_if  in  1  hazard hold; freezes pc_o and IF/ID.
flush_if_id  in  1  taken branch/jump redirect, one-cycle pulse.
pc_o  out  32  current PC register.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, equal to pc_o.
imem_gnt  in  1  request accepted.
imem_rvalid  in  1  response valid.
imem_rdata  in  32  response instruction word.
if_id_valid  out  1  IF/ID holds a real instruction.
if_id_PC_Plus_4  out  32  IF/ID captured PC+4.
if_id_Inst  out  32  IF/ID instruction.

Behaviour:
- Reset (async assert, synchronous release):
  - pc_o=RESET_PC, state=S_REQ, drop=0, hold_buf=0.
  - if_id_valid=0, if_id_Inst=NOP_INST, if_id_PC_Plus_4=0.
  - imem_req is forced 0 while reset=0.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req=1, imem_addr=pc_o.
  - imem_gnt=1 -> S_WAIT. Otherwise stay.
- S_WAIT:
  - imem_req=0. Waits for imem_rvalid.
  - rvalid with drop=1 -> discard the word, drop<=0, -> S_REQ.
  - rvalid, drop=0, stall_if=0 -> accept: if_id_valid<=1, if_id_Inst<=imem_rdata, if_id_PC_Plus_4<=pc_o+4, pc_o<=pc_next, -> S_REQ.
  - rvalid, drop=0, stall_if=1 -> hold_buf<=imem_rdata, -> S_HOLD. pc_o and IF/ID are unchanged.
- S_HOLD:
  - imem_req=0.
  - stall_if=0 -> accept from hold_buf with the same updates as above, -> S_REQ.
- imem_rvalid is ignored in S_REQ and S_HOLD. This covers stale responses after reset.
- Accept cycles vs other cycles:
  - Only accept cycles write valid data into IF/ID.
  - Any other cycle with stall_if=0 and no flush inserts a bubble: if_id_valid<=0, if_id_Inst<=NOP_INST, if_id_PC_Plus_4 unchanged.
  - stall_if=1 freezes all IF/ID fields and pc_o.
- Flush (flush_if_id=1) has priority over stall_if and over accept:
  - pc_o<=pc_next.
  - if_id_valid<=0, if_id_Inst<=NOP_INST.
  - hold_buf is invalidated.
  - In S_WAIT with rvalid=0: drop<=1, stay in S_WAIT.
  - In S_WAIT with rvalid=1: the word is discarded, -> S_REQ.
  - In S_REQ with gnt=1 the same cycle: that request is for the old PC; drop<=1, -> S_WAIT.
  - In S_REQ with gnt=0: stay in S_REQ. The new address is presented next cycle.
  - In S_HOLD: -> S_REQ.
- Width and arithmetic rules:
  - PC+4 is modulo 2^32; 0xFFFF_FFFC+4 = 0.
  - pc_o is not forced word-aligned; the upstream next-PC logic guarantees alignment.
- Throughput: at most one instruction per two cycles, because of one outstanding request and no address pipelining.

Test Plan:
1. Release reset; memory grants the same cycle and responds the next cycle with 0x2008_0001 -> imem_addr=0x0040_0000 in cycle 0. After the cycle-1 edge: if_id_Inst=0x2008_0001, if_id_PC_Plus_4=0x0040_0004, if_id_valid=1, pc_o=pc_next (drive 0x0040_0004). Next fetch in cycle 2.
2. Hold stall_if=1 from the response cycle for 3 cycles, rdata=0x8C09_0000 -> IF/ID and pc_o frozen, state S_HOLD. Drop stall -> next edge IF/ID=0x8C09_0000, valid=1.
3. In S_WAIT, pulse flush_if_id with pc_next=0x0040_0100; respond 2 cycles later -> if_id_valid=0 and NOP; response discarded; next imem_addr=0x0040_0100.
4. Flush coincident with imem_gnt in S_REQ (target 0x0040_0200) -> the following response is discarded; the next request uses address 0x0040_0200.
5. Assert reset while in S_WAIT, release, then inject a stale rvalid in the first cycle -> the stale word is ignored, imem_addr=0x0040_0000, if_id_valid=0.
6. stall_if=1 and flush_if_id=1 in the same cycle, in S_HOLD -> the flush wins: hold_buf invalidated, pc_o=pc_next, state S_REQ.
